mem_stage_unit: RTL

//  MEM-stage consumer of the EX/MEM pipeline register outputs. Holds the word-organised data memory.

---
 rtl/mem_stage_unit_if.sv | 34 +++
 rtl/mem_stage_unit.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mem_stage_unit_if.sv
// mem_stage_unit_if: bundles the EX/MEM-side access bus and the debug dump
// port of the MEM stage.
//   master : drives access controls, store data, halt marker and debug requests
//   slave  : the MEM stage; returns load data, misaligned pulse, halted flag
//            and debug read data
interface mem_stage_unit_if #(
    parameter int ADDR_W = 8
);
    logic              i_enable;
    logic              i_flush;
    logic [31:0]       i_ControlSignal;
    logic [31:0]       i_ALUResult;
    logic [31:0]       i_RegRTData;
    logic              i_halt;
    logic [31:0]       o_ReadData;
    logic              o_misaligned;
    logic              o_halted;
    logic              i_dbg_req;
    logic [ADDR_W-1:0] i_dbg_addr;
    logic [31:0]       o_dbg_data;
    logic              o_dbg_valid;

    modport master (
        output i_enable, i_flush, i_ControlSignal, i_ALUResult, i_RegRTData,
               i_halt, i_dbg_req, i_dbg_addr,
        input  o_ReadData, o_misaligned, o_halted, o_dbg_data, o_dbg_valid
    );

    modport slave (
        input  i_enable, i_flush, i_ControlSignal, i_ALUResult, i_RegRTData,
               i_halt, i_dbg_req, i_dbg_addr,
        output o_ReadData, o_misaligned, o_halted, o_dbg_data, o_dbg_valid
    );
endinterface

// File: rtl/mem_stage_unit.sv
// mem_stage_unit: MEM pipeline stage with a word-organised data memory.
// Byte/half/word stores merge into the addressed lanes; loads extract and
// sign- or zero-extend into a registered o_ReadData. On a halt marker the
// stage drains one cycle, halts, and then serves single-word debug reads.
// Ports:
//   Clock      : single clock, all state on posedge
//   i_reset_n  : asynchronous active-low reset (memory contents not reset)
//   bus        : access/debug bundle, slave side (see mem_stage_unit_if)
//
// state  | meaning
// RUN    | normal operation, loads and stores performed
// DRAIN  | halt seen; tail cycle, no writes
// HALTED | pipeline stopped; writes blocked; debug reads accepted
// DUMP   | debug read in progress; returns to HALTED
module mem_stage_unit #(
    parameter int ADDR_W       = 8,
    parameter int MEMREAD_BIT  = 5,
    parameter int MEMWRITE_BIT = 6,
    parameter int SIZE_LSB     = 7,
    parameter int UNSIGNED_BIT = 9
) (
    input logic              Clock,
    input logic              i_reset_n,
    mem_stage_unit_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED, S_DUMP} state_t;

    state_t state_q, state_d;

    logic [31:0] mem_q [0:DEPTH-1];

    logic [31:0] read_data_q, read_data_d;
    logic        misaligned_q, misaligned_d;
    logic [31:0] dbg_data_q, dbg_data_d;
    logic        dbg_valid_q, dbg_valid_d;

    logic              mem_rd, mem_wr, is_unsigned, legal;
    logic [1:0]        size, lane;
    logic [ADDR_W-1:0] word_idx;
    logic [3:0]        byte_en;
    logic [31:0]       wr_data, rd_word, load_val;
    logic              halted, dbg_accept, do_write;

    assign mem_rd      = bus.i_ControlSignal[MEMREAD_BIT];
    assign mem_wr      = bus.i_ControlSignal[MEMWRITE_BIT];
    assign is_unsigned = bus.i_ControlSignal[UNSIGNED_BIT];
    assign size        = bus.i_ControlSignal[SIZE_LSB +: 2];
    assign lane        = bus.i_ALUResult[1:0];
    assign word_idx    = bus.i_ALUResult[ADDR_W+1:2];

    always_comb begin
        case (size)
            2'b00:   legal = 1'b1;
            2'b01:   legal = ~lane[0];
            2'b10:   legal = (lane == 2'b00);
            default: legal = 1'b0;
        endcase
    end

    // Replicate store data across lanes so byte_en alone selects the target.
    always_comb begin
        byte_en = 4'b0000;
        wr_data = bus.i_RegRTData;
        case (size)
            2'b00: begin
                byte_en = 4'b0001 << lane;
                wr_data = {4{bus.i_RegRTData[7:0]}};
            end
            2'b01: begin
                byte_en = lane[1] ? 4'b1100 : 4'b0011;
                wr_data = {2{bus.i_RegRTData[15:0]}};
            end
            2'b10:   byte_en = 4'b1111;
            default: byte_en = 4'b0000;
        endcase
    end

    assign rd_word = mem_q[word_idx];

    always_comb begin
        logic [7:0]  b;
        logic [15:0] h;
        b = rd_word[{lane, 3'b000} +: 8];
        h = lane[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            2'b00:   load_val = is_unsigned ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   load_val = is_unsigned ? {16'd0, h} : {{16{h[15]}}, h};
            default: load_val = rd_word;
        endcase
    end

    // Reset gating keeps the un-reset memory from being written while
    // rst is held with a live store on the bus.
    assign do_write = i_reset_n && (state_q == S_RUN) && bus.i_enable &&
                      !bus.i_flush && mem_wr && legal;

    always_ff @(posedge Clock) begin
        if (do_write) begin
            for (int k = 0; k < 4; k++) begin
                if (byte_en[k]) mem_q[word_idx][8*k +: 8] <= wr_data[8*k +: 8];
            end
        end
    end

    // FSM: state register
    always_ff @(posedge Clock or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= S_RUN;
        else            state_q <= state_d;
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_RUN:    if (bus.i_halt && bus.i_enable && !bus.i_flush) state_d = S_DRAIN;
            S_DRAIN:  state_d = S_HALTED;
            S_HALTED: if (bus.i_dbg_req) state_d = S_DUMP;
            S_DUMP:   state_d = S_HALTED;
        endcase
    end

    // FSM: outputs
    always_comb begin
        halted     = (state_q == S_HALTED) || (state_q == S_DUMP);
        dbg_accept = (state_q == S_HALTED) && bus.i_dbg_req;
    end

    always_comb begin
        read_data_d  = read_data_q;
        misaligned_d = 1'b0;
        if (halted) begin
            read_data_d = read_data_q;
        end else if (bus.i_flush) begin
            read_data_d = 32'd0;
        end else if (bus.i_enable) begin
            if ((mem_rd || mem_wr) && !legal) begin
                read_data_d  = 32'd0;
                misaligned_d = 1'b1;
            end else if (mem_rd && !mem_wr) begin
                read_data_d = load_val;
            end else begin
                read_data_d = 32'd0;
            end
        end
    end

    always_comb begin
        dbg_valid_d = dbg_accept;
        dbg_data_d  = dbg_accept ? mem_q[bus.i_dbg_addr] : dbg_data_q;
    end

    always_ff @(posedge Clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            read_data_q  <= 32'd0;
            misaligned_q <= 1'b0;
            dbg_data_q   <= 32'd0;
            dbg_valid_q  <= 1'b0;
        end else begin
            read_data_q  <= read_data_d;
            misaligned_q <= misaligned_d;
            dbg_data_q   <= dbg_data_d;
            dbg_valid_q  <= dbg_valid_d;
        end
    end

    assign bus.o_ReadData   = read_data_q;
    assign bus.o_misaligned = misaligned_q;
    assign bus.o_halted     = halted;
    assign bus.o_dbg_data   = dbg_data_q;
    assign bus.o_dbg_valid  = dbg_valid_q;

    // Control and address bits this stage does not decode.
    logic unused_bits;
    assign unused_bits = ^{bus.i_ControlSignal, bus.i_ALUResult};
endmodule
